// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with a built-in
// test-pattern source. A pair of free-running counters walks the raster; a
// single registered output stage turns the current counter position into
// sync, data-enable, frame/line pulses and pixel colour, so every output is
// aligned and lags the counters by exactly one enabled cycle.

module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 11,
    parameter int COLOR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [CNT_W-1:0]     hcount,
    output logic [CNT_W-1:0]     vcount,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_start,
    output logic                 line_start,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Bounds are held one bit wider than the counters so that a sync pulse
    // ending exactly at 2^CNT_W (zero back porch) is still representable.
    localparam int BW = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [BW-1:0] H_VIS_B  = BW'(H_VISIBLE);
    localparam logic [BW-1:0] HS_BEG_B = BW'(H_VISIBLE + H_FP);
    localparam logic [BW-1:0] HS_END_B = BW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [BW-1:0] V_VIS_B  = BW'(V_VISIBLE);
    localparam logic [BW-1:0] VS_BEG_B = BW'(V_VISIBLE + V_FP);
    localparam logic [BW-1:0] VS_END_B = BW'(V_VISIBLE + V_FP + V_SYNC);

    // Colour-bar boundaries: left edge of bars 1..7, fixed at elaboration.
    localparam logic [BW-1:0] BAR_EDGE [1:7] = '{
        BW'((1 * H_VISIBLE) / 8),
        BW'((2 * H_VISIBLE) / 8),
        BW'((3 * H_VISIBLE) / 8),
        BW'((4 * H_VISIBLE) / 8),
        BW'((5 * H_VISIBLE) / 8),
        BW'((6 * H_VISIBLE) / 8),
        BW'((7 * H_VISIBLE) / 8)
    };

    // Zero-extended counter views wide enough for the grid and gradient
    // slices; bits above the real counter width read as zero.
    localparam int HW = COLOR_W + 4;
    localparam int VW = (COLOR_W + 2 > 5) ? COLOR_W + 2 : 5;

    localparam logic [3*COLOR_W-1:0] RGB_ZERO  = {(3*COLOR_W){1'b0}};
    localparam logic [3*COLOR_W-1:0] RGB_WHITE = {(3*COLOR_W){1'b1}};

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
        if (COLOR_W < 1) begin : g_bad_color_w
            $error("vga_timing_gen: COLOR_W must be at least 1");
        end
        if ((H_VISIBLE < 1) || (V_VISIBLE < 1) || (H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_geom
            $error("vga_timing_gen: visible area and sync widths must be non-zero");
        end
        if ((H_FP < 0) || (H_BP < 0) || (V_FP < 0) || (V_BP < 0)) begin : g_bad_porch
            $error("vga_timing_gen: porch widths must not be negative");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Index of the colour bar containing horizontal position h.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, h} >= BAR_EDGE[k]) begin
                idx = 3'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Expand a 3-bit bar index into full-scale {r,g,b} channels.
    function automatic logic [3*COLOR_W-1:0] bar_colour(input logic [2:0] idx);
        return {{COLOR_W{idx[2]}}, {COLOR_W{idx[1]}}, {COLOR_W{idx[0]}}};
    endfunction

    // ------------------------------------------------------------------
    // Internal state and decode
    // ------------------------------------------------------------------
    logic [1:0]           mode_r;
    logic [HW-1:0]        h_ext_s;
    logic [VW-1:0]        v_ext_s;
    logic                 hs_act_s;
    logic                 vs_act_s;
    logic                 vis_s;
    logic                 origin_s;
    logic                 line_head_s;
    logic [1:0]           mode_cur_s;
    logic [2:0]           bar_s;
    logic                 grid_s;
    logic [3*COLOR_W-1:0] pat_s;
    logic [3*COLOR_W-1:0] rgb_s;

    // Raster counters: advance one pixel per enabled cycle, wrap line and frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= CNT_ZERO;
            vcount <= CNT_ZERO;
        end else if (pix_en) begin
            if (hcount == H_LAST) begin
                hcount <= CNT_ZERO;
                if (vcount == V_LAST) begin
                    vcount <= CNT_ZERO;
                end else begin
                    vcount <= vcount + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                hcount <= hcount + {{(CNT_W-1){1'b0}}, 1'b1};
                vcount <= vcount;
            end
        end else begin
            hcount <= hcount;
            vcount <= vcount;
        end
    end

    // Region decode and pattern generation for the pixel the counters hold now.
    always_comb begin
        h_ext_s     = HW'(hcount);
        v_ext_s     = VW'(vcount);
        hs_act_s    = ({1'b0, hcount} >= HS_BEG_B) && ({1'b0, hcount} < HS_END_B);
        vs_act_s    = ({1'b0, vcount} >= VS_BEG_B) && ({1'b0, vcount} < VS_END_B);
        vis_s       = ({1'b0, hcount} < H_VIS_B) && ({1'b0, vcount} < V_VIS_B);
        origin_s    = (hcount == CNT_ZERO) && (vcount == CNT_ZERO);
        line_head_s = (hcount == CNT_ZERO) && ({1'b0, vcount} < V_VIS_B);
        // At pixel (0,0) the freshly sampled mode already applies, so the
        // whole new frame is drawn with one mode.
        mode_cur_s  = origin_s ? mode : mode_r;
        bar_s       = bar_index(hcount);
        grid_s      = (h_ext_s[4:0] == 5'd0) || (v_ext_s[4:0] == 5'd0);
        pat_s       = RGB_ZERO;
        case (mode_cur_s)
            2'd0:    pat_s = solid_rgb;
            2'd1:    pat_s = bar_colour(bar_s);
            2'd2:    pat_s = grid_s ? RGB_WHITE : RGB_ZERO;
            2'd3:    pat_s = {v_ext_s[COLOR_W+1:2], h_ext_s[COLOR_W+1:2], h_ext_s[COLOR_W+3:4]};
            default: pat_s = RGB_ZERO;
        endcase
        if (vis_s) begin
            rgb_s = pat_s;
        end else begin
            rgb_s = RGB_ZERO;
        end
    end

    // Output stage: register the decoded pixel; pulses last one clk only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= 2'd0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            red         <= {COLOR_W{1'b0}};
            green       <= {COLOR_W{1'b0}};
            blue        <= {COLOR_W{1'b0}};
        end else if (pix_en) begin
            mode_r      <= mode_cur_s;
            hsync       <= hs_act_s ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_act_s ? V_SYNC_POL : ~V_SYNC_POL;
            de          <= vis_s;
            frame_start <= origin_s;
            line_start  <= line_head_s;
            red         <= rgb_s[3*COLOR_W-1:2*COLOR_W];
            green       <= rgb_s[2*COLOR_W-1:COLOR_W];
            blue        <= rgb_s[COLOR_W-1:0];
        end else begin
            mode_r      <= mode_r;
            hsync       <= hsync;
            vsync       <= vsync;
            de          <= de;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            red         <= red;
            green       <= green;
            blue        <= blue;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. A small-geometry
// instance exercises pulses, bars, pix_en gating, mode latching and reset;
// a default-geometry instance (positive hsync, grid mode) runs alongside it
// for line timing and grid pixel checks.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: H 8/2/3/3 (16 total), V 4/1/2/1 (8 total), 128 clk frame
    logic        a_rst, a_pix_en;
    logic [1:0]  a_mode;
    logic [11:0] a_solid;
    logic [10:0] a_hcount, a_vcount;
    logic        a_hsync, a_vsync, a_de, a_fs, a_ls;
    logic [3:0]  a_red, a_green, a_blue;

    // Default instance with active-high hsync
    logic        b_rst, b_pix_en;
    logic [1:0]  b_mode;
    logic [11:0] b_solid;
    logic [10:0] b_hcount, b_vcount;
    logic        b_hsync, b_vsync, b_de, b_fs, b_ls;
    logic [3:0]  b_red, b_green, b_blue;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(11), .COLOR_W(4)
    ) u_small (
        .clk(clk), .rst(a_rst), .pix_en(a_pix_en), .mode(a_mode), .solid_rgb(a_solid),
        .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
        .de(a_de), .frame_start(a_fs), .line_start(a_ls),
        .red(a_red), .green(a_green), .blue(a_blue)
    );

    vga_timing_gen #(
        .H_SYNC_POL(1'b1)
    ) u_dflt (
        .clk(clk), .rst(b_rst), .pix_en(b_pix_en), .mode(b_mode), .solid_rgb(b_solid),
        .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
        .de(b_de), .frame_start(b_fs), .line_start(b_ls),
        .red(b_red), .green(b_green), .blue(b_blue)
    );

    int n_vec = 0;
    int n_err = 0;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance negedge by negedge until an instance's counters reach (h,v).
    task automatic wait_pos(input bit on_b, input int h, input int v, input int limit, input string tag);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            if (on_b) hit = (int'(b_hcount) == h) && (int'(b_vcount) == v);
            else      hit = (int'(a_hcount) == h) && (int'(a_vcount) == v);
        end
        check_val({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    function automatic logic [31:0] a_rgb();
        return 32'({a_red, a_green, a_blue});
    endfunction

    function automatic logic [31:0] b_rgb();
        return 32'({b_red, b_green, b_blue});
    endfunction

    int fs_n, ls_n, hs_n, vs_n, de_n;
    logic [10:0] h_at2, h_at3;

    initial begin
        a_rst = 1'b1; a_pix_en = 1'b1; a_mode = 2'd1; a_solid = 12'h000;
        b_rst = 1'b1; b_pix_en = 1'b1; b_mode = 2'd2; b_solid = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_hcount", 32'(a_hcount), 32'd0);
        check_val("rst_vcount", 32'(a_vcount), 32'd0);
        check_val("rst_hsync",  32'(a_hsync),  32'd1);
        check_val("rst_vsync",  32'(a_vsync),  32'd1);
        check_val("rst_de",     32'(a_de),     32'd0);
        check_val("rst_fs",     32'(a_fs),     32'd0);
        check_val("rst_ls",     32'(a_ls),     32'd0);
        check_val("rst_rgb",    a_rgb(),       32'h000);
        check_val("rst_b_hsync", 32'(b_hsync), 32'd0);
        check_val("rst_b_vsync", 32'(b_vsync), 32'd1);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // First enabled edge after reset registers pixel (0,0)
        @(negedge clk);
        check_val("first_fs",     32'(a_fs),     32'd1);
        check_val("first_ls",     32'(a_ls),     32'd1);
        check_val("first_de",     32'(a_de),     32'd1);
        check_val("first_hcount", 32'(a_hcount), 32'd1);
        check_val("first_rgb",    a_rgb(),       32'h000);

        // One full frame of output pixels (pixels 1..127 then (0,0))
        fs_n = 0; ls_n = 0; hs_n = 0; vs_n = 0; de_n = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            fs_n += int'(a_fs);
            ls_n += int'(a_ls);
            hs_n += int'(!a_hsync);
            vs_n += int'(!a_vsync);
            de_n += int'(a_de);
        end
        check_val("frame_fs_cnt", 32'(fs_n), 32'd1);
        check_val("frame_ls_cnt", 32'(ls_n), 32'd4);
        check_val("frame_hs_cnt", 32'(hs_n), 32'd24);
        check_val("frame_vs_cnt", 32'(vs_n), 32'd32);
        check_val("frame_de_cnt", 32'(de_n), 32'd32);

        // Colour bars, line pulse and sync edges, each one clk after the counter
        wait_pos(1'b0, 4, 1, 2000, "bar3");
        check_val("bar3_rgb", a_rgb(), 32'h0FF);
        wait_pos(1'b0, 1, 2, 2000, "line2");
        check_val("line2_ls", 32'(a_ls), 32'd1);
        check_val("line2_fs", 32'(a_fs), 32'd0);
        wait_pos(1'b0, 8, 2, 2000, "bar7");
        check_val("bar7_rgb", a_rgb(), 32'hFFF);
        wait_pos(1'b0, 9, 2, 2000, "hblank");
        check_val("hblank_rgb", a_rgb(), 32'h000);
        check_val("hblank_de",  32'(a_de), 32'd0);
        wait_pos(1'b0, 10, 3, 2000, "hs_pre");
        check_val("hs_pre", 32'(a_hsync), 32'd1);
        wait_pos(1'b0, 11, 3, 2000, "hs_on");
        check_val("hs_on", 32'(a_hsync), 32'd0);
        wait_pos(1'b0, 13, 3, 2000, "hs_last");
        check_val("hs_last", 32'(a_hsync), 32'd0);
        wait_pos(1'b0, 14, 3, 2000, "hs_off");
        check_val("hs_off", 32'(a_hsync), 32'd1);
        wait_pos(1'b0, 0, 5, 2000, "vs_pre");
        check_val("vs_pre", 32'(a_vsync), 32'd1);
        wait_pos(1'b0, 1, 5, 2000, "vs_on");
        check_val("vs_on", 32'(a_vsync), 32'd0);

        // pix_en alternating: one full frame at half rate
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        a_pix_en = 1'b1;
        fs_n = 0; ls_n = 0; hs_n = 0; vs_n = 0; de_n = 0;
        h_at2 = '0; h_at3 = '0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            fs_n += int'(a_fs);
            ls_n += int'(a_ls);
            hs_n += int'(!a_hsync);
            vs_n += int'(!a_vsync);
            de_n += int'(a_de);
            if (i == 2) h_at2 = a_hcount;
            if (i == 3) h_at3 = a_hcount;
            a_pix_en = (i % 2 == 0);
        end
        check_val("pe_hold_h",  32'(h_at2), 32'd1);
        check_val("pe_step_h",  32'(h_at3), 32'd2);
        check_val("pe_fs_cnt",  32'(fs_n), 32'd1);
        check_val("pe_ls_cnt",  32'(ls_n), 32'd4);
        check_val("pe_hs_cnt",  32'(hs_n), 32'd48);
        check_val("pe_vs_cnt",  32'(vs_n), 32'd64);
        check_val("pe_de_cnt",  32'(de_n), 32'd64);
        check_val("pe_end_h",   32'(a_hcount), 32'd0);
        check_val("pe_end_v",   32'(a_vcount), 32'd0);
        a_pix_en = 1'b1;

        // Mode change mid-frame takes effect only at the next frame
        a_mode  = 2'd0;
        a_solid = 12'hA5C;
        wait_pos(1'b0, 0, 2, 2000, "mode_sw");
        a_mode = 2'd3;
        wait_pos(1'b0, 8, 3, 2000, "old_frame");
        check_val("old_frame_rgb", a_rgb(), 32'hA5C);
        wait_pos(1'b0, 1, 0, 2000, "new_origin");
        check_val("new_origin_fs",  32'(a_fs), 32'd1);
        check_val("new_origin_rgb", a_rgb(), 32'h000);
        wait_pos(1'b0, 8, 3, 2000, "new_frame");
        check_val("new_frame_rgb", a_rgb(), 32'h010);

        // Reset in the middle of a frame
        wait_pos(1'b0, 5, 3, 2000, "mid_rst");
        a_rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_h",     32'(a_hcount), 32'd0);
        check_val("mid_rst_v",     32'(a_vcount), 32'd0);
        check_val("mid_rst_hsync", 32'(a_hsync),  32'd1);
        check_val("mid_rst_vsync", 32'(a_vsync),  32'd1);
        check_val("mid_rst_de",    32'(a_de),     32'd0);
        check_val("mid_rst_rgb",   a_rgb(),       32'h000);
        a_rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_fs", 32'(a_fs),     32'd1);
        check_val("post_rst_h",  32'(a_hcount), 32'd1);

        // Default geometry: one full line of line 3
        wait_pos(1'b1, 0, 3, 5000, "b_line3");
        hs_n = 0; de_n = 0;
        for (int i = 0; i < 1056; i++) begin
            @(negedge clk);
            hs_n += int'(b_hsync);
            de_n += int'(b_de);
        end
        check_val("b_hs_high_cnt", 32'(hs_n), 32'd128);
        check_val("b_de_cnt",      32'(de_n), 32'd800);

        // Grid pixels
        wait_pos(1'b1, 33, 7, 10000, "b_px_32_7");
        check_val("b_px_32_7", b_rgb(), 32'hFFF);
        wait_pos(1'b1, 34, 7, 10, "b_px_33_7");
        check_val("b_px_33_7", b_rgb(), 32'h000);
        wait_pos(1'b1, 6, 32, 30000, "b_px_5_32");
        check_val("b_px_5_32", b_rgb(), 32'hFFF);
        check_val("b_vsync_idle", 32'(b_vsync), 32'd1);
        wait_pos(1'b1, 6, 33, 2000, "b_px_5_33");
        check_val("b_px_5_33", b_rgb(), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
